// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared constants for the vscale instruction/data memory arbiter.
// Owner encodings, streak counter width and the reused vscale bus constants.
package vscale_mem_arbiter_pkg;

  localparam int XPR_LEN          = 32;
  localparam int MEM_TYPE_WIDTH   = 3;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SW = 3'd2;

  localparam int ARB_STREAK_WIDTH = 4;

  typedef enum logic {
    ARB_OWNER_IMEM = 1'b0,
    ARB_OWNER_DMEM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/vscale_mem_arbiter_grant.sv
// Combinational grant decision for the shared memory bus (vscale_arb_grant).
// Optional fetch-fairness streak limit enabled by VSCALE_ARB_FAIRNESS_EN.
module vscale_arb_grant
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                        dmem_en,
`ifdef VSCALE_ARB_FAIRNESS_EN
  input  logic                        mem_wait,
  input  logic [ARB_STREAK_WIDTH-1:0] d_streak_q,
  output logic [ARB_STREAK_WIDTH-1:0] d_streak_d,
`endif
  output logic                        d_grant,
  output logic                        d_lost
);

  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_streak
    $error("MAX_D_STREAK must be in 1..15");
  end

`ifdef VSCALE_ARB_FAIRNESS_EN
  logic force_fetch;

  // After MAX_D_STREAK consecutive data grants one address phase goes to fetch.
  always_comb begin
    force_fetch = dmem_en && (d_streak_q == ARB_STREAK_WIDTH'(MAX_D_STREAK));
    d_grant     = dmem_en && !force_fetch;
    d_lost      = force_fetch;
    d_streak_d  = d_streak_q;
    if (!mem_wait) begin
      d_streak_d = d_grant ? d_streak_q + 1'b1 : '0;
    end
  end
`else
  always_comb begin
    d_grant = dmem_en;
    d_lost  = 1'b0;
  end
`endif

endmodule

// File: rtl/vscale_mem_arbiter.sv
// Shares one pipelined memory bus between vscale's fetch and data ports.
// Define VSCALE_ARB_FAIRNESS_EN to bound consecutive data grants by MAX_D_STREAK.
module vscale_mem_arbiter
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [XPR_LEN-1:0]        imem_addr,
  output logic [XPR_LEN-1:0]        imem_rdata,
  output logic                      imem_wait,
  output logic                      imem_badmem_e,
  input  logic                      dmem_en,
  input  logic                      dmem_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [XPR_LEN-1:0]        dmem_addr,
  input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
  output logic [XPR_LEN-1:0]        dmem_rdata,
  output logic                      dmem_wait,
  output logic                      dmem_badmem_e,
  output logic                      mem_en,
  output logic                      mem_wen,
  output logic [MEM_TYPE_WIDTH-1:0] mem_size,
  output logic [XPR_LEN-1:0]        mem_addr,
  output logic [XPR_LEN-1:0]        mem_wdata,
  input  logic [XPR_LEN-1:0]        mem_rdata,
  input  logic                      mem_wait,
  input  logic                      mem_badmem_e
);

  arb_owner_e owner_q;
  logic       i_lost_q;
  logic       d_lost_q;
  logic       d_grant;
  logic       d_lost;

`ifdef VSCALE_ARB_FAIRNESS_EN
  logic [ARB_STREAK_WIDTH-1:0] d_streak_q;
  logic [ARB_STREAK_WIDTH-1:0] d_streak_d;
`endif

  vscale_arb_grant #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_grant (
    .dmem_en    (dmem_en),
`ifdef VSCALE_ARB_FAIRNESS_EN
    .mem_wait   (mem_wait),
    .d_streak_q (d_streak_q),
    .d_streak_d (d_streak_d),
`endif
    .d_grant    (d_grant),
    .d_lost     (d_lost)
  );

  // Ownership only advances once the current data phase has completed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q  <= ARB_OWNER_IMEM;
      i_lost_q <= 1'b0;
      d_lost_q <= 1'b0;
    end else if (!mem_wait) begin
      owner_q  <= d_grant ? ARB_OWNER_DMEM : ARB_OWNER_IMEM;
      i_lost_q <= d_grant;
      d_lost_q <= d_lost;
    end
  end

`ifdef VSCALE_ARB_FAIRNESS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_streak_q <= '0;
    end else begin
      d_streak_q <= d_streak_d;
    end
  end
`endif

  // Fetch always requests, so the bus is busy every cycle.
  always_comb begin
    mem_en   = 1'b1;
    mem_wen  = d_grant && dmem_wen;
    mem_size = d_grant ? dmem_size : MEM_TYPE_SW;
    mem_addr = d_grant ? dmem_addr : imem_addr;
  end

  // Status outputs are forced quiet while reset is asserted.
  always_comb begin
    mem_wdata     = dmem_wdata_delayed;
    imem_rdata    = mem_rdata;
    dmem_rdata    = mem_rdata;
    imem_wait     = reset_n && (i_lost_q || (owner_q == ARB_OWNER_IMEM && mem_wait));
    dmem_wait     = reset_n && (d_lost_q || (owner_q == ARB_OWNER_DMEM && mem_wait));
    imem_badmem_e = reset_n && owner_q == ARB_OWNER_IMEM && mem_badmem_e;
    dmem_badmem_e = reset_n && owner_q == ARB_OWNER_DMEM && mem_badmem_e;
  end

endmodule

// File: doc/vscale_mem_arbiter.md
# vscale_mem_arbiter

Shares one pipelined single-port memory bus between the vscale pipeline's instruction-fetch port and its data port, for platforms with a single unified SRAM or bus. It sits between `vscale_pipeline` and the memory. On conflict it decides which port owns each address phase and routes the data phase back to the correct port. Conflicts are resolved by stretching the losing port with its `*_wait`. Uncontended accesses see zero added latency.

## Interface
- `MAX_D_STREAK`, default 4: consecutive data grants allowed before fetch is forced through. Used only with `VSCALE_ARB_FAIRNESS_EN`. Range 1..15.
- `clk`  in  1  clock
- `reset_n`  in  1  reset, **synchronous, active-low**
- `imem_addr`  in  XPR_LEN  fetch address; fetch always requests
- `imem_rdata`  out  XPR_LEN  fetch data, valid in the data phase
- `imem_wait`  out  1  fetch data phase not complete
- `imem_badmem_e`  out  1  fetch bus error
- `dmem_en`, `dmem_wen`  in  1  data request and write
- `dmem_size`  in  MEM_TYPE_WIDTH  access size
- `dmem_addr`  in  XPR_LEN  data address
- `dmem_wdata_delayed`  in  XPR_LEN  store data, presented in the data phase
- `dmem_rdata`  out  XPR_LEN  load data
- `dmem_wait`, `dmem_badmem_e`  out  1  data wait and data bus error
- `mem_en`, `mem_wen`  out  1  bus request and write
- `mem_size`  out  MEM_TYPE_WIDTH  bus access size
- `mem_addr`  out  XPR_LEN  bus address
- `mem_wdata`  out  XPR_LEN  bus write data, data phase
- `mem_rdata`  in  XPR_LEN  bus read data
- `mem_wait`, `mem_badmem_e`  in  1  bus wait and bus error

## Operation
**Bus protocol**
- Address phase in cycle N, data phase in N+1.
- `mem_wait` high extends the data phase. The next address phase is held until the data phase completes.

**Grant (combinational)**
- Default: data wins whenever `dmem_en` is high; otherwise fetch.
- `mem_addr`, `mem_en`, `mem_wen` and `mem_size` are muxed from the winner.
- On a fetch grant: `mem_en`=1, `mem_wen`=0, `mem_size`=word.

**Registered state**, updated only when `mem_wait`=0:
- `owner_q` (IMEM/DMEM): which port owns the current data phase. Reset value IMEM.
- `i_lost_q`: fetch lost the previous address phase. Reset 0.
- `d_lost_q`: data lost the previous address phase. Reset 0.

**Data-phase routing**
- `mem_rdata` drives both `imem_rdata` and `dmem_rdata`.
- `mem_wdata` = `dmem_wdata_delayed`.
- `mem_badmem_e` goes only to the owner's `*_badmem_e`.

**Wait outputs**
- `imem_wait` = `i_lost_q` | (`owner_q`==IMEM & `mem_wait`).
- `dmem_wait` = `d_lost_q` | (`owner_q`==DMEM & `mem_wait`).

**Retry**
- The losing port holds its request, because the pipeline stalls.
- It is granted in the next address phase, unless it loses again.

**Reset mid-transfer**
- All state returns to its reset value.
- The in-flight data phase is dropped; the bus must also be reset.

## Timing
- Uncontended fetch or data access: same latency as a direct bus connection.
- Conflict in cycle N: data is granted. `imem_wait`=1 in N+1. Fetch is re-issued in N+1 and its data completes in N+2 (with no further conflict).
- Stretched data phase: if `mem_wait` holds for k cycles, both state and the grant are frozen for those k cycles.
- Outputs during reset:
  - `imem_wait`=0, `dmem_wait`=0, `*_badmem_e`=0.
  - `mem_en` follows the grant logic, so a fetch grant drives `mem_en`=1.

## Configuration
- **`VSCALE_ARB_FAIRNESS_EN` defined:**
  - A 4-bit `d_streak_q` counts consecutive data grants; reset value 0.
  - It clears on any fetch grant.
  - When `d_streak_q`==`MAX_D_STREAK` and `dmem_en`=1, fetch is granted instead. `d_lost_q` is set, and the counter clears.
- **Undefined:** strict data priority and no counter. Fetch can starve under back-to-back data accesses.

## Structure
- Shared package/header `vscale_arb_constants.vh`:
  - owner encodings `ARB_OWNER_IMEM`=0, `ARB_OWNER_DMEM`=1
  - streak counter width
- Reuse the existing constants: `XPR_LEN`, `MEM_TYPE_WIDTH`, `MEM_TYPE_SW`.
- One natural sub-module: `vscale_arb_grant`, combinational, computing the grant from `dmem_en`, `mem_wait` and the streak state.

## Test plan
- **Idle fetch.** Fetch only at addr 0x200, `mem_rdata`=0x13. Expect `mem_addr`=0x200, `imem_rdata`=0x13 next cycle, `imem_wait`=0.
- **Conflict.** Fetch at 0x204 and `dmem_en`=1 load at 0x1000 in the same cycle. Expect `mem_addr`=0x1000, then `imem_wait`=1 with `dmem_rdata` valid, then `mem_addr`=0x204.
- **Store data phase.** Store SW at 0x2000 with `dmem_wdata_delayed`=0xDEADBEEF in N+1. Expect `mem_wen`=1 in N and `mem_wdata`=0xDEADBEEF in N+1.
- **Wait stretch.** DMEM owner with `mem_wait`=1 for 3 cycles. Expect `dmem_wait`=1 for 3 cycles, `imem_wait` held at 1, grant frozen.
- **Error routing.** `mem_badmem_e`=1 during a fetch data phase. Expect `imem_badmem_e`=1 and `dmem_badmem_e`=0.
- **Fairness** (macro defined, `MAX_D_STREAK`=4). 6 back-to-back loads. Expect the 5th address phase granted to fetch, `dmem_wait`=1 that data phase, and the 5th load completing one cycle later.
